// File: rtl/b06_arbiter_if.sv
// Bus between the b06 arbiter and its requesters / shared b06 instance.
// The slave modport is the arbiter's view; master is the driving side.
interface b06_arbiter_if;
   logic [3:0] req;
   logic [3:0] req_cont;
   logic       ackout;
   logic [3:0] grant;
   logic       eql;
   logic       cont_eql;
   logic       busy;
   logic [3:0] done;
   logic       timeout;

   modport slave (
      input  req, req_cont, ackout,
      output grant, eql, cont_eql, busy, done, timeout
   );

   modport master (
      output req, req_cont, ackout,
      input  grant, eql, cont_eql, busy, done, timeout
   );
endinterface

// File: rtl/b06_arbiter.sv
// Round-robin arbiter sharing one b06 instance among four requesters.
// Each grant is held until ackout, a request drop, or a cycle timeout.
module b06_arbiter #(
   parameter int unsigned TIMEOUT = 15
) (
   input logic         clock,
   input logic         reset,
   b06_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      WAIT_ACK,
      RELEASE
   } state_t;

   localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

   state_t     state, state_next;
   logic [1:0] sel, sel_next;
   logic [1:0] ptr, ptr_next;
   logic [1:0] pick;
   logic [7:0] cnt, cnt_next;

   logic [3:0] grant_q, grant_next;
   logic       eql_q, eql_next;
   logic       cont_eql_q, cont_eql_next;
   logic       busy_q, busy_next;
   logic [3:0] done_q, done_next;
   logic       timeout_q, timeout_next;

   // Scan downward so the requester closest after ptr is the last one written.
   always_comb begin
      pick = ptr + 2'd1;
      for (int k = 3; k >= 0; k--) begin
         if (bus.req[2'(ptr + 2'd1 + 2'(k))]) begin
            pick = 2'(ptr + 2'd1 + 2'(k));
         end
      end
   end

   always_comb begin
      state_next    = state;
      sel_next      = sel;
      ptr_next      = ptr;
      cnt_next      = cnt;
      grant_next    = grant_q;
      eql_next      = eql_q;
      cont_eql_next = cont_eql_q;
      done_next     = 4'b0000;
      timeout_next  = 1'b0;

      unique case (state)
         IDLE: begin
            grant_next    = 4'b0000;
            eql_next      = 1'b0;
            cont_eql_next = 1'b0;
            if (bus.req != 4'b0000) begin
               sel_next   = pick;
               state_next = GRANT;
            end
         end
         GRANT: begin
            grant_next    = 4'b0001 << sel;
            eql_next      = 1'b1;
            cont_eql_next = bus.req_cont[sel];
            cnt_next      = 8'd0;
            state_next    = WAIT_ACK;
         end
         WAIT_ACK: begin
            cont_eql_next = bus.req_cont[sel];
            if (bus.ackout || !bus.req[sel] || cnt == LAST_CNT) begin
               grant_next    = 4'b0000;
               eql_next      = 1'b0;
               cont_eql_next = 1'b0;
               state_next    = RELEASE;
               if (bus.ackout) begin
                  done_next = 4'b0001 << sel;
               end else if (bus.req[sel]) begin
                  timeout_next = 1'b1;
               end
            end else begin
               cnt_next = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
            end
         end
         RELEASE: begin
            grant_next    = 4'b0000;
            eql_next      = 1'b0;
            cont_eql_next = 1'b0;
            ptr_next      = sel;
            state_next    = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      busy_next = (state_next != IDLE);
   end

   // ptr resets to 3 so that requester 0 is first in line.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         sel        <= 2'd0;
         ptr        <= 2'd3;
         cnt        <= 8'd0;
         grant_q    <= 4'b0000;
         eql_q      <= 1'b0;
         cont_eql_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 4'b0000;
         timeout_q  <= 1'b0;
      end else begin
         state      <= state_next;
         sel        <= sel_next;
         ptr        <= ptr_next;
         cnt        <= cnt_next;
         grant_q    <= grant_next;
         eql_q      <= eql_next;
         cont_eql_q <= cont_eql_next;
         busy_q     <= busy_next;
         done_q     <= done_next;
         timeout_q  <= timeout_next;
      end
   end

   assign bus.grant    = grant_q;
   assign bus.eql      = eql_q;
   assign bus.cont_eql = cont_eql_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.timeout  = timeout_q;

endmodule

// File: tb/tb_b06_arbiter.sv
// Directed bench for b06_arbiter (TIMEOUT=4): round robin, ack, timeout,
// abort, ackout priority and asynchronous reset mid-transaction.
module tb_b06_arbiter;

   logic clock;
   logic reset;
   int   total;
   int   bad;

   b06_arbiter_if bus();

   b06_arbiter #(.TIMEOUT(4)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic applyStimulus(input logic [3:0] r, input logic [3:0] rc, input logic a);
      bus.req      = r;
      bus.req_cont = rc;
      bus.ackout   = a;
   endtask

   task automatic checkOutput(input string tag, input logic [3:0] g, input logic e,
                              input logic ce, input logic b, input logic [3:0] d,
                              input logic t);
      logic [11:0] obs;
      logic [11:0] exp;
      obs = {bus.grant, bus.eql, bus.cont_eql, bus.busy, bus.done, bus.timeout};
      exp = {g, e, ce, b, d, t};
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got grant=%b eql=%b cont=%b busy=%b done=%b to=%b, want grant=%b eql=%b cont=%b busy=%b done=%b to=%b",
                tag, obs[11:8], obs[7], obs[6], obs[5], obs[4:1], obs[0],
                exp[11:8], exp[7], exp[6], exp[5], exp[4:1], exp[0]);
      end
   endtask

   initial begin
      logic [3:0] rr_grant [5];
      logic       rr_cont  [5];
      total = 0;
      bad   = 0;
      rr_grant = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      rr_cont  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

      reset = 1'b0;
      applyStimulus(4'b0000, 4'b0000, 1'b0);
      #1;
      checkOutput("reset", 4'b0000, 0, 0, 0, 4'b0000, 0);
      step();
      step();
      reset = 1'b1;

      // Round robin with all requesters asking; ack in the first WAIT_ACK cycle
      applyStimulus(4'b1111, 4'b1010, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step();
         checkOutput("rr_grantstate", 4'b0000, 0, 0, 1, 4'b0000, 0);
         step();
         checkOutput("rr_grant", rr_grant[i], 1, rr_cont[i], 1, 4'b0000, 0);
         bus.ackout = 1'b1;
         step();
         checkOutput("rr_done", 4'b0000, 0, 0, 1, rr_grant[i], 0);
         bus.ackout = 1'b0;
         step();
         checkOutput("rr_idle", 4'b0000, 0, 0, 0, 4'b0000, 0);
      end

      // Single requester, ack on the third WAIT_ACK cycle
      applyStimulus(4'b0001, 4'b0001, 1'b0);
      step();
      step();
      checkOutput("a_wait1", 4'b0001, 1, 1, 1, 4'b0000, 0);
      step();
      checkOutput("a_wait2", 4'b0001, 1, 1, 1, 4'b0000, 0);
      step();
      checkOutput("a_wait3", 4'b0001, 1, 1, 1, 4'b0000, 0);
      bus.ackout = 1'b1;
      step();
      checkOutput("a_done", 4'b0000, 0, 0, 1, 4'b0001, 0);
      applyStimulus(4'b0000, 4'b0000, 1'b0);
      step();
      checkOutput("a_idle", 4'b0000, 0, 0, 0, 4'b0000, 0);

      // Timeout after four WAIT_ACK cycles; ackout in IDLE/GRANT is ignored
      applyStimulus(4'b0100, 4'b0100, 1'b1);
      step();
      checkOutput("c_grantstate", 4'b0000, 0, 0, 1, 4'b0000, 0);
      step();
      checkOutput("c_wait1", 4'b0100, 1, 1, 1, 4'b0000, 0);
      bus.ackout = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         checkOutput("c_hold", 4'b0100, 1, 1, 1, 4'b0000, 0);
      end
      step();
      checkOutput("c_timeout", 4'b0000, 0, 0, 1, 4'b0000, 1);
      applyStimulus(4'b0000, 4'b0000, 1'b0);
      step();
      checkOutput("c_idle", 4'b0000, 0, 0, 0, 4'b0000, 0);

      // Request drop coinciding with ackout: ackout wins
      applyStimulus(4'b0010, 4'b0000, 1'b0);
      step();
      step();
      checkOutput("d_grant", 4'b0010, 1, 0, 1, 4'b0000, 0);
      applyStimulus(4'b0000, 4'b0000, 1'b1);
      step();
      checkOutput("d_done", 4'b0000, 0, 0, 1, 4'b0010, 0);
      bus.ackout = 1'b0;
      step();
      checkOutput("d_idle", 4'b0000, 0, 0, 0, 4'b0000, 0);

      // Other requests arriving are ignored; dropping req[sel] aborts silently
      applyStimulus(4'b0010, 4'b0010, 1'b0);
      step();
      step();
      checkOutput("e_grant", 4'b0010, 1, 1, 1, 4'b0000, 0);
      applyStimulus(4'b0011, 4'b0000, 1'b0);
      step();
      checkOutput("e_hold", 4'b0010, 1, 0, 1, 4'b0000, 0);
      bus.req = 4'b0001;
      step();
      checkOutput("e_abort", 4'b0000, 0, 0, 1, 4'b0000, 0);
      bus.req = 4'b0000;
      step();
      checkOutput("e_idle", 4'b0000, 0, 0, 0, 4'b0000, 0);

      // Asynchronous reset in WAIT_ACK, then requester 3 after release
      applyStimulus(4'b1000, 4'b0000, 1'b0);
      step();
      step();
      checkOutput("f_grant", 4'b1000, 1, 0, 1, 4'b0000, 0);
      #2;
      reset = 1'b0;
      #1;
      checkOutput("f_async", 4'b0000, 0, 0, 0, 4'b0000, 0);
      step();
      checkOutput("f_inreset", 4'b0000, 0, 0, 0, 4'b0000, 0);
      reset = 1'b1;
      step();
      checkOutput("f_grantstate", 4'b0000, 0, 0, 1, 4'b0000, 0);
      step();
      checkOutput("f_regrant", 4'b1000, 1, 0, 1, 4'b0000, 0);
      bus.ackout = 1'b1;
      step();
      checkOutput("f_done", 4'b0000, 0, 0, 1, 4'b1000, 0);
      applyStimulus(4'b0000, 4'b0000, 1'b0);
      step();
      checkOutput("f_idle", 4'b0000, 0, 0, 0, 4'b0000, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/b06_arbiter.md
B06_ARBITER -- requirements
Module: b06_arbiter

Interface
REQ-001 The module SHALL have parameter TIMEOUT, default 15, meaning the number of cycles to wait for ackout before abandoning a grant (legal range 1..255).
REQ-002 The module SHALL have port clock, input, 1 bit: the single clock; all flops are rising-edge.
REQ-003 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-004 The module SHALL have port req, input, 4 bits: per-requester request level, bit i = requester i.
REQ-005 The module SHALL have port req_cont, input, 4 bits: per-requester cont_eql value to forward while granted.
REQ-006 The module SHALL have port ackout, input, 1 bit: acknowledge from the shared b06 instance.
REQ-007 The module SHALL have port grant, output, 4 bits: one-hot grant, or all-zero.
REQ-008 The module SHALL have port eql, output, 1 bit: drives b06 eql.
REQ-009 The module SHALL have port cont_eql, output, 1 bit: drives b06 cont_eql.
REQ-010 The module SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-011 The module SHALL have port done, output, 4 bits: one-cycle pulse on bit i when requester i's transaction is acknowledged.
REQ-012 The module SHALL have port timeout, output, 1 bit: one-cycle pulse when a grant expires without ackout.

Function
REQ-013 The FSM SHALL have exactly four states: IDLE, GRANT, WAIT_ACK and RELEASE; all outputs SHALL be registered.
REQ-014 IDLE: when req != 0, the FSM SHALL latch sel, the first set req bit searching upward (mod 4) from ptr+1, and SHALL move to GRANT; otherwise it SHALL stay in IDLE.
REQ-015 GRANT (1 cycle): grant SHALL equal onehot(sel), eql SHALL be 1, cont_eql SHALL be req_cont[sel], cnt SHALL be cleared to 0, and the next state SHALL be WAIT_ACK.
REQ-016 WAIT_ACK: grant and eql SHALL be held, cont_eql SHALL track req_cont[sel] each cycle, and cnt SHALL increment once per cycle (8-bit counter, saturating at 255).
REQ-017 WAIT_ACK exits: if ackout=1, the FSM SHALL go to RELEASE and pulse done[sel]; else if req[sel]=0, it SHALL go to RELEASE with no pulse (abort); else if cnt reached TIMEOUT-1, it SHALL go to RELEASE and pulse timeout.
REQ-018 Priority when exit conditions coincide SHALL be ackout > abort > timeout, and at most one of done and timeout SHALL pulse per transaction.
REQ-019 RELEASE (1 cycle): grant, eql and cont_eql SHALL be 0, ptr SHALL be set to sel, and the next state SHALL be IDLE; a new grant SHALL not issue earlier than 2 cycles after RELEASE.
REQ-020 Request-to-eql latency SHALL be 2 edges: req sampled in IDLE at edge N, eql=1 visible after edge N+1.
REQ-021 Round-robin fairness: with all req bits held high, grants SHALL cycle 0,1,2,3,0,...
REQ-022 req changes outside IDLE, other than req[sel], SHALL have no effect on the current transaction.
REQ-023 ackout received in IDLE, GRANT or RELEASE SHALL be ignored.

Reset
REQ-024 reset=0 SHALL asynchronously force: state=IDLE, grant=0, eql=0, cont_eql=0, busy=0, done=0, timeout=0, cnt=0, ptr=3 (so requester 0 wins first).
REQ-025 Reset asserted mid-transaction SHALL drop grant and eql immediately, with no done or timeout pulse.
REQ-026 After reset deasserts, the first arbitration SHALL occur at the first rising edge with reset=1.

Verification
REQ-027 Scenario: req=0001, req_cont=0001, ackout=1 at 3rd WAIT_ACK cycle -> grant=0001, eql=1, cont_eql=1; done=0001 for one cycle; grant=0000 in RELEASE.
REQ-028 Scenario: req=1111 held, ackout pulsed once per WAIT_ACK -> grant sequence 0001,0010,0100,1000,0001.
REQ-029 Scenario: TIMEOUT=4, req=0100, ackout held 0 -> exactly 4 WAIT_ACK cycles, then timeout=1 for one cycle, done=0000.
REQ-030 Scenario: req=0010 dropped to 0000 in WAIT_ACK while ackout=1 on the same cycle -> done=0010 (ackout wins); ackout=0 in the same case -> abort, no pulse.
REQ-031 Scenario: reset=0 asserted asynchronously mid-WAIT_ACK -> grant=0000, eql=0, busy=0 before the next edge; after release with req=1000, grant=1000.
